// File: rtl/pli_assert_monitor_if.sv
// rtl/pli_assert_monitor_if.sv - event, checker and status bundle for the assertion monitor
interface pli_assert_monitor_if #(
   parameter int unsigned DBG_W = 8,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned VEC_W = 8
);
   logic             dbg_wr;
   logic [DBG_W-1:0] dbg_wdata;
   logic [DBG_W-1:0] debug_level;
   logic [DBG_W-1:0] info_level;
   logic             info_en;
   logic             err_evt;
   logic             warn_evt;
   logic             cov_evt;
   logic             chk_valid;
   logic             chk_mode;
   logic [VEC_W-1:0] chk_vec;
   logic             req;
   logic             ack;
   logic [CNT_W-1:0] error_count;
   logic [CNT_W-1:0] warn_count;
   logic [CNT_W-1:0] cover_count;
   logic [2:0]       fail_flags;
   logic             stop_req;

   modport master (
      output dbg_wr, dbg_wdata, info_level, err_evt, warn_evt, cov_evt,
             chk_valid, chk_mode, chk_vec, req, ack,
      input  debug_level, info_en, error_count, warn_count, cover_count,
             fail_flags, stop_req
   );

   modport slave (
      input  dbg_wr, dbg_wdata, info_level, err_evt, warn_evt, cov_evt,
             chk_valid, chk_mode, chk_vec, req, ack,
      output debug_level, info_en, error_count, warn_count, cover_count,
             fail_flags, stop_req
   );
endinterface

// File: rtl/pli_assert_monitor.sv
// rtl/pli_assert_monitor.sv - global debug level, event counters, one-hot and req/ack checkers
module pli_assert_monitor #(
   parameter int unsigned DBG_W         = 8,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned VEC_W         = 8,
   parameter int unsigned ERROR_LIMIT   = 1,
   parameter int unsigned DEFAULT_DEBUG = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pli_assert_monitor_if.slave  bus
);
   localparam int unsigned POP_W = $clog2(VEC_W + 1);

   typedef enum logic {IDLE, PEND} ra_state_e;

   ra_state_e        state_q, state_d;
   logic [DBG_W-1:0] debug_level_q, debug_level_d;
   logic [CNT_W-1:0] error_count_q, error_count_d;
   logic [CNT_W-1:0] warn_count_q, warn_count_d;
   logic [CNT_W-1:0] cover_count_q, cover_count_d;
   logic [2:0]       fail_flags_q, fail_flags_d;
   logic             stop_req_q, stop_req_d;

   logic [POP_W-1:0] pop;
   logic             vec_fail;
   logic             ra_fail;
   logic [1:0]       n_src;
   logic [CNT_W:0]   err_sum;

   always_comb begin
      pop = '0;
      for (int i = 0; i < VEC_W; i++) begin
         pop = pop + POP_W'(bus.chk_vec[i]);
      end
      vec_fail = bus.chk_valid &&
                 (bus.chk_mode ? (pop != POP_W'(1)) : (pop > POP_W'(1)));
   end

   // Only one outstanding request is tracked; a simultaneous req/ack in PEND retires the old one.
   always_comb begin
      state_d = state_q;
      ra_fail = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req && !bus.ack)      state_d = PEND;
            else if (!bus.req && bus.ack) ra_fail = 1'b1;
         end
         PEND: begin
            if (bus.ack && !bus.req)      state_d = IDLE;
            else if (bus.req && !bus.ack) ra_fail = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      debug_level_d = bus.dbg_wr ? bus.dbg_wdata : debug_level_q;

      n_src = {1'b0, bus.err_evt} + {1'b0, vec_fail} + {1'b0, ra_fail};
      err_sum = {1'b0, error_count_q} + (CNT_W + 1)'(n_src);
      error_count_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

      warn_count_d  = warn_count_q;
      if (bus.warn_evt && (warn_count_q != '1)) warn_count_d = warn_count_q + 1'b1;
      cover_count_d = cover_count_q;
      if (bus.cov_evt && (cover_count_q != '1)) cover_count_d = cover_count_q + 1'b1;

      fail_flags_d = fail_flags_q | {ra_fail, vec_fail, bus.err_evt};

      // Compared against the next count so stop_req rises together with the limit-reaching error.
      stop_req_d = stop_req_q ||
                   ((ERROR_LIMIT != 0) && (64'(error_count_d) >= 64'(ERROR_LIMIT)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         debug_level_q <= DBG_W'(DEFAULT_DEBUG);
         error_count_q <= '0;
         warn_count_q  <= '0;
         cover_count_q <= '0;
         fail_flags_q  <= '0;
         stop_req_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         debug_level_q <= debug_level_d;
         error_count_q <= error_count_d;
         warn_count_q  <= warn_count_d;
         cover_count_q <= cover_count_d;
         fail_flags_q  <= fail_flags_d;
         stop_req_q    <= stop_req_d;
      end
   end

   assign bus.debug_level = debug_level_q;
   assign bus.info_en     = (bus.info_level <= debug_level_q);
   assign bus.error_count = error_count_q;
   assign bus.warn_count  = warn_count_q;
   assign bus.cover_count = cover_count_q;
   assign bus.fail_flags  = fail_flags_q;
   assign bus.stop_req    = stop_req_q;
endmodule

// File: tb/tb_pli_assert_monitor.sv
// tb/tb_pli_assert_monitor.sv - directed scoreboard bench for pli_assert_monitor
module tb_pli_assert_monitor;
   logic clk;
   logic rst_n;

   pli_assert_monitor_if #(.DBG_W(8), .CNT_W(16), .VEC_W(8)) bus ();
   pli_assert_monitor_if #(.DBG_W(8), .CNT_W(2),  .VEC_W(8)) bus2 ();

   pli_assert_monitor #(
      .DBG_W(8), .CNT_W(16), .VEC_W(8), .ERROR_LIMIT(1), .DEFAULT_DEBUG(0)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   pli_assert_monitor #(
      .DBG_W(8), .CNT_W(2), .VEC_W(8), .ERROR_LIMIT(1), .DEFAULT_DEBUG(0)
   ) dut_sat (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [7:0]  dbg;
      logic        info;
      logic [15:0] err;
      logic [15:0] warn;
      logic [15:0] cov;
      logic [2:0]  flags;
      logic        stop;
      logic [1:0]  cov2;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   int          exp_dbg, exp_err, exp_warn, exp_cov, exp_cov2;
   logic        exp_info, exp_stop;
   logic [2:0]  exp_flags;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
      end
   endtask

   task automatic reset_exp();
      exp_dbg = 0; exp_err = 0; exp_warn = 0; exp_cov = 0; exp_cov2 = 0;
      exp_flags = 3'b000; exp_stop = 1'b0;
   endtask

   // Push the expectation for this cycle, clock once, then pop and compare.
   task automatic step(input string tag);
      exp_t e;
      e.tag = tag; e.dbg = 8'(exp_dbg); e.info = exp_info; e.err = 16'(exp_err);
      e.warn = 16'(exp_warn); e.cov = 16'(exp_cov); e.flags = exp_flags;
      e.stop = exp_stop; e.cov2 = 2'(exp_cov2);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_mis++;
         $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".debug_level"}, 32'(bus.debug_level), 32'(e.dbg));
         chk({e.tag, ".info_en"},     32'(bus.info_en),     32'(e.info));
         chk({e.tag, ".error_count"}, 32'(bus.error_count), 32'(e.err));
         chk({e.tag, ".warn_count"},  32'(bus.warn_count),  32'(e.warn));
         chk({e.tag, ".cover_count"}, 32'(bus.cover_count), 32'(e.cov));
         chk({e.tag, ".fail_flags"},  32'(bus.fail_flags),  32'(e.flags));
         chk({e.tag, ".stop_req"},    32'(bus.stop_req),    32'(e.stop));
         chk({e.tag, ".sat_cover"},   32'(bus2.cover_count), 32'(e.cov2));
      end
   endtask

   initial begin
      bus.dbg_wr = 0; bus.dbg_wdata = 0; bus.info_level = 0; bus.err_evt = 0;
      bus.warn_evt = 0; bus.cov_evt = 0; bus.chk_valid = 0; bus.chk_mode = 0;
      bus.chk_vec = 0; bus.req = 0; bus.ack = 0;
      bus2.dbg_wr = 0; bus2.dbg_wdata = 0; bus2.info_level = 0; bus2.err_evt = 0;
      bus2.warn_evt = 0; bus2.cov_evt = 0; bus2.chk_valid = 0; bus2.chk_mode = 0;
      bus2.chk_vec = 0; bus2.req = 0; bus2.ack = 0;
      rst_n = 1'b0;
      reset_exp();
      exp_info = 1'b1;
      step("reset0");
      step("reset1");
      rst_n = 1'b1;

      bus.info_level = 8'd1;  exp_info = 1'b0; step("info_l1");
      bus.dbg_wr = 1'b1; bus.dbg_wdata = 8'd9; bus.info_level = 8'd9;
      exp_dbg = 9; exp_info = 1'b1; step("dbg_wr9");
      bus.dbg_wr = 1'b0;
      bus.info_level = 8'd10; exp_info = 1'b0; step("info_l10");
      bus.info_level = 8'd0;  exp_info = 1'b1; step("info_l0");

      bus.chk_valid = 1'b1; bus.chk_mode = 1'b0;
      bus.chk_vec = 8'h04; step("m0_04");
      bus.chk_vec = 8'h02; step("m0_02");
      bus.chk_vec = 8'h01; step("m0_01");
      bus.chk_vec = 8'h00; step("m0_00");
      bus.chk_vec = 8'h03; exp_err = 1; exp_flags[1] = 1'b1; exp_stop = 1'b1; step("m0_03");

      bus.chk_mode = 1'b1;
      bus.chk_vec = 8'h02; step("m1_02");
      bus.chk_vec = 8'h01; step("m1_01");
      bus.chk_vec = 8'h00; exp_err = 2; step("m1_00");
      bus.chk_vec = 8'h03; exp_err = 3; step("m1_03");
      bus.chk_valid = 1'b0; bus.chk_vec = 8'hFF; step("chk_idle");

      bus.req = 1'b1; step("ra_req");
      bus.req = 1'b0; step("ra_wait");
      bus.ack = 1'b1; step("ra_ack");
      bus.ack = 1'b1; exp_err = 4; exp_flags[2] = 1'b1; step("ra_orphan_ack");
      bus.ack = 1'b0;
      bus.req = 1'b1; step("ra_req_a");
      bus.req = 1'b0; step("ra_gap");
      bus.req = 1'b1; exp_err = 5; step("ra_req_b");
      bus.req = 1'b0; bus.ack = 1'b1; step("ra_close");
      bus.ack = 1'b0;

      bus.err_evt = 1'b1; bus.chk_valid = 1'b1; bus.chk_mode = 1'b1; bus.chk_vec = 8'h00;
      bus.ack = 1'b1; exp_err = 8; exp_flags = 3'b111; step("triple");
      bus.err_evt = 1'b0; bus.chk_valid = 1'b0; bus.ack = 1'b0;

      bus.warn_evt = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         exp_warn = i;
         step($sformatf("warn%0d", i));
      end
      bus.warn_evt = 1'b0;

      bus.cov_evt = 1'b1; bus2.cov_evt = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         exp_cov = i;
         exp_cov2 = (i > 3) ? 3 : i;
         step($sformatf("cov%0d", i));
      end
      bus.cov_evt = 1'b0; bus2.cov_evt = 1'b0;

      bus.req = 1'b1; step("pend_before_rst");
      bus.req = 1'b0;
      rst_n = 1'b0; bus.warn_evt = 1'b1; bus.err_evt = 1'b1;
      reset_exp(); exp_info = 1'b1; step("mid_reset");
      rst_n = 1'b1; bus.warn_evt = 1'b0; bus.err_evt = 1'b0;
      bus.ack = 1'b1; exp_err = 1; exp_flags[2] = 1'b1; exp_stop = 1'b1; step("post_rst_idle");
      bus.ack = 1'b0; step("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
